// File: rtl/ps2_voice_alloc.sv
// PS/2 Set-2 scan-code parser feeding a round-robin-stealing voice allocator.
// Emits per-slot gate/code/ext and one-cycle note_on/note_off strobes.
module ps2_voice_alloc #(
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned VIDX_W      = 2,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                    clk_50Mhz,
  input  logic                    rst_n,
  input  logic [7:0]              code,
  input  logic                    code_strobe,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [8*NUM_VOICES-1:0] voice_code,
  output logic [NUM_VOICES-1:0]   voice_ext,
  output logic                    note_on,
  output logic                    note_off,
  output logic [VIDX_W-1:0]       event_voice
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXT    = 2'd1,
    S_BRK    = 2'd2,
    S_EXTBRK = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   tmo_cnt, tmo_cnt_d;
  logic               make_c, brk_c, ext_c;
  logic               hit_c, free_c;
  logic [VIDX_W-1:0]  hit_idx_c, free_idx_c, slot_c;
  logic [VIDX_W-1:0]  steal_ptr;

  // Bytes that carry no key information (pause prefix, errors, BAT/ACK/resend).
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == 8'hE1) || (b == 8'h00) || (b == 8'hAA) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tmo_cnt <= '0;
    end else begin
      state   <= state_d;
      tmo_cnt <= tmo_cnt_d;
    end
  end

  // Prefix parser: emits make/break decode for the byte in this strobe cycle.
  always_comb begin
    state_d   = state;
    tmo_cnt_d = tmo_cnt;
    make_c    = 1'b0;
    brk_c     = 1'b0;
    ext_c     = 1'b0;
    if (code_strobe) begin
      tmo_cnt_d = '0;
      case (state)
        S_IDLE: begin
          if (code == 8'hE0)      state_d = S_EXT;
          else if (code == 8'hF0) state_d = S_BRK;
          else if (!is_ignored(code)) make_c = 1'b1;
        end
        S_EXT: begin
          if (code == 8'hF0)      state_d = S_EXTBRK;
          else if (code == 8'hE0) state_d = S_EXT;
          else begin
            state_d = S_IDLE;
            if (!is_ignored(code)) begin
              make_c = 1'b1;
              ext_c  = 1'b1;
            end
          end
        end
        S_BRK: begin
          state_d = S_IDLE;
          if (!is_ignored(code)) brk_c = 1'b1;
        end
        S_EXTBRK: begin
          state_d = S_IDLE;
          if (!is_ignored(code)) begin
            brk_c = 1'b1;
            ext_c = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state != S_IDLE) begin
      if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
        state_d   = S_IDLE;
        tmo_cnt_d = '0;
      end else begin
        tmo_cnt_d = tmo_cnt + CNT_W'(1);
      end
    end
  end

  // Slot lookup: matching held key, lowest free slot, and the chosen target.
  always_comb begin
    hit_c      = 1'b0;
    hit_idx_c  = '0;
    free_c     = 1'b0;
    free_idx_c = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!voice_gate[v]) begin
        free_c     = 1'b1;
        free_idx_c = VIDX_W'(v);
      end
      if (voice_gate[v] && (voice_code[8*v +: 8] == code) && (voice_ext[v] == ext_c)) begin
        hit_c     = 1'b1;
        hit_idx_c = VIDX_W'(v);
      end
    end
    slot_c = free_c ? free_idx_c : steal_ptr;
  end

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      voice_gate  <= '0;
      voice_code  <= '0;
      voice_ext   <= '0;
      note_on     <= 1'b0;
      note_off    <= 1'b0;
      event_voice <= '0;
      steal_ptr   <= '0;
    end else begin
      note_on  <= 1'b0;
      note_off <= 1'b0;
      if (make_c && !hit_c) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (VIDX_W'(v) == slot_c) begin
            voice_gate[v]         <= 1'b1;
            voice_code[8*v +: 8]  <= code;
            voice_ext[v]          <= ext_c;
          end
        end
        note_on     <= 1'b1;
        event_voice <= slot_c;
        // Pointer only advances when a slot was actually stolen.
        if (!free_c) steal_ptr <= steal_ptr + VIDX_W'(1);
      end else if (brk_c && hit_c) begin
        voice_gate[hit_idx_c] <= 1'b0;
        note_off              <= 1'b1;
        event_voice           <= hit_idx_c;
      end
    end
  end

endmodule

// File: tb/tb_ps2_voice_alloc.sv
// Bench for ps2_voice_alloc: directed scenarios plus random byte streams,
// compared against a key-table model built from the parsing/allocation rules.
module tb_ps2_voice_alloc;

  localparam int N   = 4;
  localparam int TMO = 50000;

  logic            clk_50Mhz = 1'b0;
  logic            rst_n;
  logic [7:0]      code;
  logic            code_strobe;
  logic [N-1:0]    voice_gate;
  logic [8*N-1:0]  voice_code;
  logic [N-1:0]    voice_ext;
  logic            note_on;
  logic            note_off;
  logic [1:0]      event_voice;

  always #10 clk_50Mhz = ~clk_50Mhz;

  ps2_voice_alloc #(.NUM_VOICES(N), .VIDX_W(2), .TIMEOUT_CYC(TMO)) dut (
    .clk_50Mhz   (clk_50Mhz),
    .rst_n       (rst_n),
    .code        (code),
    .code_strobe (code_strobe),
    .voice_gate  (voice_gate),
    .voice_code  (voice_code),
    .voice_ext   (voice_ext),
    .note_on     (note_on),
    .note_off    (note_off),
    .event_voice (event_voice)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: table of held keys plus pending-prefix flags.
  bit         m_gate [N];
  logic [7:0] m_code [N];
  bit         m_ext  [N];
  int         m_ptr;
  bit         m_on, m_off;
  int         m_ev;
  bit         p_ext, p_brk;
  int         idle_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0]   eg, ee;
    logic [8*N-1:0] ec;
    for (int v = 0; v < N; v++) begin
      eg[v]          = m_gate[v];
      ee[v]          = m_ext[v];
      ec[8*v +: 8]   = m_code[v];
    end
    chk({tag, ":gate"},  32'(voice_gate),  32'(eg));
    chk({tag, ":code"},  32'(voice_code),  32'(ec));
    chk({tag, ":ext"},   32'(voice_ext),   32'(ee));
    chk({tag, ":on"},    32'(note_on),     32'(m_on));
    chk({tag, ":off"},   32'(note_off),    32'(m_off));
    chk({tag, ":voice"}, 32'(event_voice), 32'(m_ev));
  endtask

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_gate[v] = 0;
      m_code[v] = 8'h00;
      m_ext[v]  = 0;
    end
    m_ptr = 0; m_on = 0; m_off = 0; m_ev = 0;
    p_ext = 0; p_brk = 0; idle_cnt = 0;
  endtask

  task automatic model_make(input logic [7:0] b, input bit e);
    int slot;
    slot = -1;
    for (int v = 0; v < N; v++)
      if (m_gate[v] && m_code[v] == b && m_ext[v] == e) return;
    for (int v = 0; v < N; v++)
      if (!m_gate[v] && slot < 0) slot = v;
    if (slot < 0) begin
      slot  = m_ptr;
      m_ptr = (m_ptr + 1) % N;
    end
    m_gate[slot] = 1;
    m_code[slot] = b;
    m_ext[slot]  = e;
    m_on = 1;
    m_ev = slot;
  endtask

  task automatic model_break(input logic [7:0] b, input bit e);
    for (int v = 0; v < N; v++)
      if (m_gate[v] && m_code[v] == b && m_ext[v] == e) begin
        m_gate[v] = 0;
        m_off = 1;
        m_ev  = v;
        return;
      end
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit ign, e;
    ign = (b == 8'hE1) || (b == 8'h00) || (b == 8'hAA) ||
          (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    idle_cnt = 0;
    if (p_brk) begin
      e = p_ext; p_ext = 0; p_brk = 0;
      if (!ign) model_break(b, e);
    end else if (p_ext) begin
      if (b == 8'hF0) p_brk = 1;
      else if (b != 8'hE0) begin
        p_ext = 0;
        if (!ign) model_make(b, 1);
      end
    end else begin
      if (b == 8'hE0)      p_ext = 1;
      else if (b == 8'hF0) p_brk = 1;
      else if (!ign)       model_make(b, 0);
    end
  endtask

  // Called at a negedge; leaves the strobe high so a following send is back-to-back.
  task automatic send(input logic [7:0] b);
    code = b;
    code_strobe = 1'b1;
    @(negedge clk_50Mhz);
    m_on = 0; m_off = 0;
    model_byte(b);
    check_all($sformatf("byte_%h", b));
  endtask

  task automatic idle(input int n);
    code_strobe = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50Mhz);
      m_on = 0; m_off = 0;
      if (p_ext || p_brk) begin
        idle_cnt++;
        if (idle_cnt >= TMO) begin
          p_ext = 0; p_brk = 0;
        end
      end
      if (i == 0) check_all("idle");
    end
  endtask

  task automatic do_reset();
    code_strobe = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50Mhz);
    model_reset();
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk_50Mhz);
    check_all("post_reset");
  endtask

  logic [7:0] pool [14];

  initial begin
    pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h75,
             8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hE1};
    rst_n = 1'b0;
    code = 8'h00;
    code_strobe = 1'b0;
    model_reset();
    @(negedge clk_50Mhz);
    do_reset();

    // Single press and release
    send(8'h1C); idle(2);
    send(8'hF0); send(8'h1C); idle(2);

    // Typematic repeats produce one note_on
    send(8'h1C); idle(1); send(8'h1C); idle(1); send(8'h1C); idle(1);
    send(8'hF0); send(8'h1C); idle(1);

    // Fill all slots then steal round-robin; released stolen key is silent
    send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B); idle(1);
    send(8'h34); idle(1);
    send(8'h33); idle(1);
    send(8'hF0); send(8'h1C); idle(1);
    send(8'h43); idle(1);
    do_reset();

    // Extended vs plain key with the same code
    send(8'hE0); send(8'h75); idle(1);
    send(8'h75); idle(1);
    send(8'hE0); send(8'hF0); send(8'h75); idle(2);
    do_reset();

    // Pending break prefix times out; next byte is a make
    send(8'hF0);
    idle(TMO);
    send(8'h1C); idle(1);
    do_reset();

    // Reset discards a pending E0; ignore-set bytes produce nothing
    send(8'hE0);
    do_reset();
    send(8'h1C); idle(1);
    send(8'hAA); idle(1);
    send(8'hFA); idle(1);
    do_reset();

    // Random byte stream with random gaps (including back-to-back strobes)
    for (int k = 0; k < 600; k++) begin
      send(pool[$urandom_range(0, 13)]);
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_voice_alloc.md
Name: ps2_voice_alloc

Overview:
- Controller between the PS/2 scan-code receiver (ps2key/top_key output byte stream) and the synth voice bank.
- Parses Set-2 make/break/extended byte sequences into key events.
- Allocates held keys onto NUM_VOICES voice slots: suppresses typematic repeats and steals a slot round-robin when all are busy.
- Outputs per-voice gate and key code, plus one-cycle note_on/note_off event strobes for downstream envelope logic.

Parameters:
- NUM_VOICES, 4, number of voice slots (power of 2, 2..8).
- VIDX_W, 2, voice index width; must equal log2(NUM_VOICES).
- TIMEOUT_CYC, 50000, clk cycles (1 ms @ 50 MHz) a pending prefix may wait for its next byte before the parser aborts.

Ports:
- clk_50Mhz  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- code  input  8  received scan-code byte; valid only when code_strobe=1.
- code_strobe  input  1  one-cycle pulse, one per received byte.
- voice_gate  output  NUM_VOICES  bit v=1 while slot v holds a key.
- voice_code  output  8*NUM_VOICES  key code of slot v in bits [8v+7:8v].
- voice_ext  output  NUM_VOICES  slot v key carried an E0 prefix.
- note_on  output  1  one-cycle pulse: a slot was (re)assigned.
- note_off  output  1  one-cycle pulse: a slot was released.
- event_voice  output  VIDX_W  slot index for note_on/note_off; held until the next event.

Behaviour:
- Reset (async assert, sync deassert by design): all voice_gate/voice_ext=0, voice_code=0, note_on=note_off=0, event_voice=0, parser=IDLE, steal pointer=0, timeout counter=0.
- Parser FSM advances only on code_strobe:
  - IDLE: E0->EXT; F0->BRK; E1, 00, AA, FA, FE, FF -> ignored, stay IDLE; any other byte -> make(code, ext=0), stay IDLE.
  - EXT: F0->EXTBRK; E0 -> stay EXT; ignore-set byte -> IDLE; other -> make(code, ext=1), IDLE.
  - BRK: any non-ignore byte -> break(code, ext=0), IDLE; ignore-set byte -> IDLE.
  - EXTBRK: non-ignore byte -> break(code, ext=1), IDLE; ignore-set byte -> IDLE.
- Timeout: in EXT/BRK/EXTBRK the counter increments each cycle without code_strobe. At TIMEOUT_CYC-1 the parser returns to IDLE with no event. The counter clears on every code_strobe and on entry to IDLE.
- Key identity = {ext, code}. Matching compares both fields.
- Make event:
  - Key already in a gated slot: no change, no pulse (typematic repeat).
  - Otherwise, if a free slot exists: take the lowest-index free slot.
  - Otherwise: take the slot at the steal pointer, then increment the pointer (wraps NUM_VOICES-1 -> 0).
  - Writes gate=1, code, ext; note_on=1; event_voice=slot.
  - A steal issues only note_on; no note_off for the evicted key.
- Break event:
  - Matching gated slot found: gate=0, note_off=1, event_voice=slot. code/ext retain their last value.
  - No match (stolen or never held): no change, no pulse.
- Latency: slot outputs and pulses update on the clock edge after the code_strobe cycle carrying the final byte (1-cycle latency).
- note_on and note_off are never both 1 in the same cycle; at most one event per strobe.
- Reset mid-sequence (e.g. after F0) discards the prefix; the next byte is parsed from IDLE.
- A code_strobe on consecutive cycles is legal and each byte is processed.

Test Plan:
- Strobe 1C -> next cycle note_on=1, event_voice=0, voice_gate=0001, voice_code[7:0]=1C, voice_ext[0]=0. Then strobe F0,1C -> note_off=1, event_voice=0, voice_gate=0000.
- Strobe 1C three times (typematic) -> exactly one note_on, voice_gate=0001.
- Strobe 1C,1B,23,2B (slots 0-3 full), then 34 -> slot 0 replaced by 34, note_on, event_voice=0, steal pointer=1. Then 33 -> replaces slot 1. Then F0,1C -> no note_off.
- Strobe E0,75 then 75 -> two slots: slot0={ext=1,75}, slot1={ext=0,75}. Then E0,F0,75 -> note_off, event_voice=0, slot1 still gated.
- Strobe F0, idle 50000 cycles, strobe 1C -> note_on for 1C (treated as make, not break).
- Strobe E0, assert rst_n=0 for 3 cycles, release, strobe 1C -> voice_ext[0]=0. Also strobe AA and FA -> no events.
